feature_pool_packer: RTL and testbench

- Upstream feeder for the malaria-cell classifier.
- Accepts one raster-scan grayscale frame over a valid/ready pixel stream, average-pools it in POOL×POOL blocks, and quantizes each block to a 4-bit element.
- Packs the elements into the VECTOR_BITS feature vector, then pulses cls_start and holds the vector stable until the classifier asserts cls_done.

---
 rtl/feature_pkg.sv | 21 ++
 rtl/feature_quant.sv | 29 ++
 rtl/feature_pool_packer.sv | 141 ++++++++++++++
 tb/tb_feature_pool_packer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/feature_pkg.sv
// Shared types and width helpers for the feature pooling / packing datapath.
// Elements are 4-bit; widths derive from frame geometry and pool size.
package feature_pkg;

  localparam int ELEM_BITS    = 4;
  localparam int DEF_IMG_W    = 32;
  localparam int DEF_IMG_H    = 32;
  localparam int DEF_POOL     = 4;
  localparam int DEF_PIX_BITS = 8;

  function automatic int acc_width(input int pix_bits, input int pool);
    return pix_bits + 2 * $clog2(pool);
  endfunction

  function automatic int vector_width(input int img_w, input int img_h, input int pool);
    return (img_w / pool) * (img_h / pool) * ELEM_BITS;
  endfunction

  typedef enum logic [1:0] {IDLE, ACCUM, ISSUE, WAIT} state_t;

endpackage

// File: rtl/feature_quant.sv
// Combinational block-sum to 4-bit quantizer, zero latency, no flow control.
// FEATURE_QUANT_ROUND_EN selects round-to-nearest with saturation; default truncates.
module feature_quant
  import feature_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]     sum_i,
  output logic [ELEM_BITS-1:0] elem_o
);

`ifdef FEATURE_QUANT_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (ACC_W - 5);

  logic [ACC_W:0] rnd_sum;
  logic           unused_rnd_lsb;

  assign rnd_sum        = {1'b0, sum_i} + HALF;
  // A carry into the extra MSB means the rounded value reached 16.
  assign elem_o         = rnd_sum[ACC_W] ? {ELEM_BITS{1'b1}} : rnd_sum[ACC_W-1 -: ELEM_BITS];
  assign unused_rnd_lsb = ^rnd_sum[ACC_W-ELEM_BITS-1:0];
`else
  logic unused_sum_lsb;

  assign elem_o         = sum_i[ACC_W-1 -: ELEM_BITS];
  assign unused_sum_lsb = ^sum_i[ACC_W-ELEM_BITS-1:0];
`endif

endmodule

// File: rtl/feature_pool_packer.sv
// Average-pools a raster frame into 4-bit elements, packs them, hands the vector to the classifier.
// cls_start 1 cycle after last pixel; pix_ready low from ISSUE until cls_done (+1 cycle). Option: FEATURE_QUANT_ROUND_EN.
module feature_pool_packer
  import feature_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int POOL     = DEF_POOL,
  parameter int PIX_BITS = DEF_PIX_BITS
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        pix_valid,
  input  logic [PIX_BITS-1:0]                         pix_data,
  input  logic                                        pix_sof,
  output logic                                        pix_ready,
  output logic [vector_width(IMG_W, IMG_H, POOL)-1:0] feature_vector,
  output logic                                        cls_start,
  input  logic                                        cls_done,
  output logic                                        sof_err
);

  localparam int OUT_W       = IMG_W / POOL;
  localparam int OUT_H       = IMG_H / POOL;
  localparam int VECTOR_SIZE = OUT_W * OUT_H;
  localparam int VECTOR_BITS = vector_width(IMG_W, IMG_H, POOL);
  localparam int ACC_W       = acc_width(PIX_BITS, POOL);
  localparam int P_W         = $clog2(POOL);
  localparam int X_W         = $clog2(IMG_W);
  localparam int Y_W         = $clog2(IMG_H);

  state_t                   state_q, state_d;
  logic [X_W-1:0]           x_q, x_d;
  logic [Y_W-1:0]           y_q, y_d;
  logic [ACC_W-1:0]         acc_q [OUT_W];
  logic [ACC_W-1:0]         acc_d [OUT_W];
  logic [VECTOR_BITS-1:0]   vec_q, vec_d;
  logic                     sof_err_q, sof_err_d;

  logic                     accept;
  logic [X_W-P_W-1:0]       bx;
  logic [Y_W-P_W-1:0]       by;
  logic [ACC_W-1:0]         pix_ext;
  logic [ACC_W-1:0]         blk_sum;
  logic [ELEM_BITS-1:0]     elem;
  logic                     blk_done;
  logic                     last_pix;
  int                       elem_idx;

  assign pix_ready = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept    = pix_valid && pix_ready;
  assign bx        = x_q[X_W-1:P_W];
  assign by        = y_q[Y_W-1:P_W];
  assign pix_ext   = {{(ACC_W-PIX_BITS){1'b0}}, pix_data};
  assign blk_sum   = acc_q[bx] + pix_ext;
  assign blk_done  = (&x_q[P_W-1:0]) && (&y_q[P_W-1:0]);
  assign last_pix  = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
  assign elem_idx  = int'(by) * OUT_W + int'(bx);

  feature_quant #(.ACC_W(ACC_W)) u_quant (
    .sum_i  (blk_sum),
    .elem_o (elem)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    vec_d     = vec_q;
    sof_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && pix_sof) begin
          for (int i = 0; i < OUT_W; i++) acc_d[i] = '0;
          acc_d[0] = pix_ext;
          x_d      = X_W'(1);
          y_d      = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && pix_sof) begin
          // Restart: old nibbles stay, the new frame overwrites all of them.
          for (int i = 0; i < OUT_W; i++) acc_d[i] = '0;
          acc_d[0]  = pix_ext;
          x_d       = X_W'(1);
          y_d       = '0;
          sof_err_d = 1'b1;
        end else if (accept) begin
          if (blk_done) begin
            acc_d[bx] = '0;
            for (int k = 0; k < VECTOR_SIZE; k++) begin
              if (k == elem_idx) vec_d[VECTOR_BITS-1-ELEM_BITS*k -: ELEM_BITS] = elem;
            end
          end else begin
            acc_d[bx] = blk_sum;
          end
          if (last_pix) begin
            x_d     = '0;
            y_d     = '0;
            state_d = ISSUE;
          end else if (x_q == X_W'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cls_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
      vec_q     <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      vec_q     <= vec_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign cls_start      = (state_q == ISSUE);
  assign feature_vector = vec_q;
  assign sof_err        = sof_err_q;

endmodule

// File: tb/tb_feature_pool_packer.sv
// Directed bench for feature_pool_packer at default geometry (32x32, POOL=4, 8-bit pixels).
module tb_feature_pool_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_sof;
  logic         pix_ready;
  logic [255:0] feature_vector;
  logic         cls_start;
  logic         cls_done;
  logic         sof_err;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  int sof_errs = 0;
  int s0, e0;

  logic [255:0] pattern_vec;
  logic [255:0] exp78;

  feature_pool_packer dut (
    .clk            (clk),
    .rst            (rst),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_sof        (pix_sof),
    .pix_ready      (pix_ready),
    .feature_vector (feature_vector),
    .cls_start      (cls_start),
    .cls_done       (cls_done),
    .sof_err        (sof_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cls_start) starts++;
    if (sof_err)   sof_errs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [3:0] nib);
    logic [255:0] v;
    for (int i = 0; i < 64; i++) v[i*4 +: 4] = nib;
    return v;
  endfunction

  task automatic push(input logic [7:0] d, input logic sof);
    int guard;
    guard     = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    while (!pix_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $error("FAIL push_timeout: observed=pix_ready low expected=high within 2000 cycles");
    end
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  // mode 0: constant c; mode 1: block k filled with (k%16)<<4
  task automatic send_frame(input int mode, input logic [7:0] c, input bit gaps,
                            input int first, input int last_excl);
    for (int n = first; n < last_excl; n++) begin
      int x, y, k, g;
      logic [7:0] v;
      x = n % 32;
      y = n / 32;
      k = (y / 4) * 8 + (x / 4);
      v = (mode == 1) ? 8'((k % 16) << 4) : c;
      if (gaps) begin
        g = 0;
        while (g < 4 && $urandom_range(0, 1) == 1) begin
          tick();
          g++;
        end
      end
      push(v, n == 0);
    end
  endtask

  task automatic frame_done(input string tag, input logic [255:0] exp);
    chk({tag, "_start_hi"}, 256'(cls_start), 256'(1));
    chk({tag, "_rdy_issue"}, 256'(pix_ready), 256'(0));
    chk({tag, "_vec"}, feature_vector, exp);
    tick();
    chk({tag, "_start_lo"}, 256'(cls_start), 256'(0));
    chk({tag, "_starts"}, 256'(starts - s0), 256'(1));
  endtask

  task automatic release_vec(input string tag);
    cls_done = 1'b1;
    tick();
    cls_done = 1'b0;
    chk({tag, "_rdy_after_done"}, 256'(pix_ready), 256'(1));
  endtask

  initial begin
    pattern_vec = {4{64'h0123456789ABCDEF}};
`ifdef FEATURE_QUANT_ROUND_EN
    exp78 = rep(4'h8);
`else
    exp78 = rep(4'h7);
`endif
    rst = 1'b1; pix_valid = 1'b0; pix_data = 8'h00; pix_sof = 1'b0; cls_done = 1'b0;
    tick();
    tick();
    chk("rst_rdy", 256'(pix_ready), 256'(0));
    chk("rst_vec", feature_vector, 256'(0));
    chk("rst_start", 256'(cls_start), 256'(0));
    chk("rst_sof_err", 256'(sof_err), 256'(0));
    rst = 1'b0;
    #1;
    chk("idle_rdy", 256'(pix_ready), 256'(1));

    // Uniform 0xFF, continuous valid; cls_done during ISSUE must be ignored
    s0 = starts;
    send_frame(0, 8'hFF, 1'b0, 0, 1024);
    chk("ff_start_hi", 256'(cls_start), 256'(1));
    chk("ff_vec", feature_vector, rep(4'hF));
    cls_done = 1'b1;
    tick();
    cls_done = 1'b0;
    chk("ff_done_in_issue_ignored", 256'(pix_ready), 256'(0));
    chk("ff_starts", 256'(starts - s0), 256'(1));
    release_vec("ff");

    // Block-constant pattern, continuous
    s0 = starts;
    send_frame(1, 8'h00, 1'b0, 0, 1024);
    frame_done("pat", pattern_vec);
    release_vec("pat");

    // Same pattern with random gaps; pixels offered in WAIT must not move anything
    s0 = starts;
    send_frame(1, 8'h00, 1'b1, 0, 1024);
    frame_done("gap", pattern_vec);
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pix_data = 8'($urandom_range(0, 255));
      chk("wait_rdy", 256'(pix_ready), 256'(0));
      tick();
      chk("wait_vec", feature_vector, pattern_vec);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    release_vec("gap");

    // 0x78: truncates to 7, rounds to 8
    s0 = starts;
    send_frame(0, 8'h78, 1'b0, 0, 1024);
    frame_done("q78", exp78);
    release_vec("q78");

    // Leading non-sof pixels dropped, then a frame aborted after 300 pixels
    e0 = sof_errs;
    s0 = starts;
    for (int i = 0; i < 5; i++) push(8'hFF, 1'b0);
    send_frame(0, 8'h00, 1'b0, 0, 300);
    chk("lead_no_sof_err", 256'(sof_errs - e0), 256'(0));
    push(8'h40, 1'b1);
    chk("sof_err_hi", 256'(sof_err), 256'(1));
    tick();
    chk("sof_err_lo", 256'(sof_err), 256'(0));
    send_frame(0, 8'h40, 1'b0, 1, 1024);
    frame_done("restart", rep(4'h4));
    chk("restart_sof_errs", 256'(sof_errs - e0), 256'(1));
    release_vec("restart");

    // Reset in ACCUM
    send_frame(0, 8'h20, 1'b0, 0, 100);
    rst = 1'b1;
    tick();
    chk("rstA_rdy", 256'(pix_ready), 256'(0));
    chk("rstA_vec", feature_vector, 256'(0));
    chk("rstA_start", 256'(cls_start), 256'(0));
    chk("rstA_sof_err", 256'(sof_err), 256'(0));
    rst = 1'b0;
    #1;
    chk("rstA_idle_rdy", 256'(pix_ready), 256'(1));
    push(8'hFF, 1'b0);
    s0 = starts;
    send_frame(0, 8'h20, 1'b0, 0, 1024);
    frame_done("rstA_frame", rep(4'h2));

    // Reset in WAIT
    rst = 1'b1;
    tick();
    chk("rstW_rdy", 256'(pix_ready), 256'(0));
    chk("rstW_vec", feature_vector, 256'(0));
    chk("rstW_start", 256'(cls_start), 256'(0));
    rst = 1'b0;
    #1;
    chk("rstW_idle_rdy", 256'(pix_ready), 256'(1));
    s0 = starts;
    send_frame(0, 8'h20, 1'b0, 0, 1024);
    frame_done("rstW_frame", rep(4'h2));
    release_vec("rstW_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
